input_unit_loader: RTL
======================

Name: input_unit_loader

Overview:
- Writer side of the input-unit memory interface that snn_core reads through addr_input_unit/q_input.
- Accepts a byte stream from the UART receiver, packs 784 pixel bits into an internal 1024x1 RAM, and pulses start to snn_core.
- Waits for done, latches the digit, and serves snn_core's synchronous reads from the RAM.
- Replaces rom_input_unit in the top level, so images are loaded at run time rather than fixed in ROM.

Parameters:
NUM_PIXELS, 784, pixel bits per image; must be a multiple of 8 in packed mode
ADDR_W, 10, RAM address width; depth is 2**ADDR_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  UART byte valid; level, held until rx_clr_rdy
rx_data  input  8  UART byte
rx_clr_rdy  output  1  one-cycle pulse acknowledging the consumed byte
addr_input_unit  input  ADDR_W  read address from snn_core
q_input  output  1  RAM data at addr_input_unit, one-cycle latency
start  output  1  one-cycle pulse to snn_core
done  input  1  snn_core completion; pulse or level, rising edge used
digit  input  4  snn_core result, valid while done is high
result  output  4  latched digit
result_vld  output  1  one-cycle pulse when result updates
busy  output  1  high in all states except LOAD when pix_cnt==0
overrun  output  1  sticky; set when a byte arrives outside LOAD

Behaviour:
- Reset values (asynchronous): state=LOAD, pix_cnt=0, rx_clr_rdy=0, start=0, result=0, result_vld=0, overrun=0, q_input=0.
- RAM contents are not reset.
- RAM read is synchronous: q_input at cycle N+1 = mem[addr_input_unit sampled at cycle N]. Reads are always permitted.
- A write and a read to the same address in the same cycle return the old data.
- State LOAD:
  - On rx_rdy=1 with rx_clr_rdy=0, consume rx_data and pulse rx_clr_rdy for one cycle.
  - Write rx_data[0..7] to mem[pix_cnt..pix_cnt+7], LSB first, one bit per cycle over 8 cycles. A byte_busy flag blocks new bytes during these 8 cycles.
  - pix_cnt advances by 1 per bit written.
  - When pix_cnt reaches NUM_PIXELS-1 and that bit is written: pix_cnt returns to 0, then go to START.
- State START: assert start for exactly one cycle, then go to WAIT.
- State WAIT: on a done rising edge, capture digit into result, pulse result_vld next cycle, then return to LOAD.
- Bytes arriving in START or WAIT:
  - acknowledged with rx_clr_rdy so the UART does not stall;
  - data discarded;
  - overrun set to 1, which clears only on reset.
- done in LOAD or START is ignored.
- pix_cnt never exceeds NUM_PIXELS-1; addresses NUM_PIXELS..1023 are never written.
- Reset mid-load: pix_cnt returns to 0, the partial image is abandoned, and the next byte starts at address 0.
- rx_rdy held high across two bytes: each byte is acknowledged exactly once, and no second acknowledge is issued while rx_clr_rdy is high.
- Throughput: 1 byte per 9 cycles maximum (1 acknowledge plus 8 writes); the last byte write completes before START.
- Latency: start is asserted 1 cycle after the final pixel write.

Optional Feature:
- Macro: INPUT_UNIT_ASCII_EN.
- Defined:
  - Each byte is one pixel. 0x30 ('0') writes 0 and 0x31 ('1') writes 1, with a one-cycle write per byte.
  - Any other byte (CR, LF, space) is acknowledged and ignored, with no pix_cnt change.
  - An image takes NUM_PIXELS valid characters.
- Undefined: packed mode as above (8 pixels per byte, 98 bytes per image).
- All other behaviour is identical.

Test Plan:
1. Reset, then send 98 bytes of 0xA5 -> mem[0..783] follows pattern 1,0,1,0,0,1,0,1 repeating; start is a single pulse 1 cycle after the last write; busy=1 until the done edge.
2. After load, drive addr_input_unit=0,1,2,783 on consecutive cycles -> q_input=1,0,1,1 one cycle later each.
3. In WAIT, drive digit=4'd7 with done=1 for 1 cycle -> result=7, result_vld pulses once, state returns to LOAD with pix_cnt=0.
4. Send 1 byte during WAIT -> rx_clr_rdy pulses, overrun=1, RAM unchanged; overrun stays 1 through the next full image.
5. Send 50 bytes, assert rst_n=0 for 2 cycles, then send 98 bytes of 0xFF -> exactly one start pulse, after byte 98 of the second burst; mem[0..783] all 1.
6. With INPUT_UNIT_ASCII_EN defined, send '1', LF, '0' repeated to 784 pixels -> mem alternates 1,0; LF bytes acknowledged with no address advance; start pulses after the 784th digit character.

Source files
------------

// File: rtl/input_unit_loader.sv
// Loads a UART byte stream into a 1-bit-wide image RAM, starts snn_core and latches its digit.
// Build with INPUT_UNIT_ASCII_EN for one pixel per '0'/'1' character; default packs 8 pixels/byte.
module input_unit_loader #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              rx_clr_rdy,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic [3:0]        result,
  output logic              result_vld,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {StLoad, StStart, StWait} state_e;

  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NUM_PIXELS - 1);

  logic              mem [2**ADDR_W];
  state_e            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic              done_q;
  logic              take;
  logic              wr_en;
  logic              wr_bit;

`ifdef INPUT_UNIT_ASCII_EN
  logic is_digit;

  assign is_digit = (rx_data == 8'h30) || (rx_data == 8'h31);
  assign take     = rx_rdy && !rx_clr_rdy;
  // Each '0'/'1' character is written in the same cycle it is acknowledged.
  assign wr_en    = (state == StLoad) && take && is_digit;
  assign wr_bit   = rx_data[0];
`else
  logic       byte_busy;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  assign take   = rx_rdy && !rx_clr_rdy && !byte_busy;
  assign wr_en  = (state == StLoad) && byte_busy;
  assign wr_bit = shreg[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StLoad;
      pix_cnt    <= '0;
      rx_clr_rdy <= 1'b0;
      start      <= 1'b0;
      result     <= '0;
      result_vld <= 1'b0;
      overrun    <= 1'b0;
      done_q     <= 1'b0;
`ifndef INPUT_UNIT_ASCII_EN
      byte_busy  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
`endif
    end else begin
      rx_clr_rdy <= take;
      start      <= 1'b0;
      result_vld <= 1'b0;
      done_q     <= done;
      // Bytes outside LOAD are still acknowledged so the UART never stalls.
      if (take && (state != StLoad)) overrun <= 1'b1;
`ifndef INPUT_UNIT_ASCII_EN
      if (take && (state == StLoad)) begin
        byte_busy <= 1'b1;
        shreg     <= rx_data;
        bit_cnt   <= '0;
      end
      if (wr_en) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_busy <= 1'b0;
      end
`endif
      unique case (state)
        StLoad: begin
          if (wr_en) begin
            if (pix_cnt == LastPix) begin
              pix_cnt <= '0;
              state   <= StStart;
              start   <= 1'b1;
`ifndef INPUT_UNIT_ASCII_EN
              byte_busy <= 1'b0;
`endif
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end
          end
        end
        StStart: state <= StWait;
        StWait: begin
          if (done && !done_q) begin
            result     <= digit;
            result_vld <= 1'b1;
            state      <= StLoad;
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

  // Write-first ordering is not wanted: a same-address read returns the old bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[pix_cnt] <= wr_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_input <= 1'b0;
    else        q_input <= mem[addr_input_unit];
  end

  assign busy = !((state == StLoad) && (pix_cnt == '0));

endmodule
